// File: rtl/seg_disp_arbiter_if.sv
// Requester/display-side signal bundle for the 7-segment display arbiter.
// master = requesters and display driver, slave = the arbiter.
interface seg_disp_arbiter_if;
  logic [2:0]  req;
  logic [15:0] din0;
  logic [15:0] din1;
  logic [15:0] din2;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic [15:0] disp_x;
  logic        disp_en;
  logic        switch_pulse;

  modport master (
    output req, din0, din1, din2,
    input  gnt, owner, disp_x, disp_en, switch_pulse
  );

  modport slave (
    input  req, din0, din1, din2,
    output gnt, owner, disp_x, disp_en, switch_pulse
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner selection for a shared 4-digit 7-segment display, with a
// minimum dwell time so each granted value stays on screen long enough to read.
module seg_disp_arbiter #(
  parameter int DWELL = 50000000,
  parameter int CNT_W = 26
) (
  input logic             clk,
  input logic             clr,
  seg_disp_arbiter_if.slave bus
);

  localparam int                 DATA_W  = 16;
  localparam logic [1:0]         NO_OWN  = 2'd3;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DWELL - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state, state_n;
  logic [1:0]          owner_q, owner_n;
  logic [1:0]          last, last_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [2:0]          gnt_q;
  logic [DATA_W-1:0]   disp_q, disp_n;
  logic                en_q;
  logic                pulse_q, pulse_n;
  logic [2:0]          others;
  logic [2:0]          pick;

  // {found, index}: first set bit of r searching ptr+1, ptr+2, ptr (mod 3)
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] c;
    rr_pick = 3'b000;
    c = ptr;
    for (int i = 0; i < 3; i++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (r[c] && !rr_pick[2]) rr_pick = {1'b1, c};
    end
  endfunction

  // The current owner is masked out, so "next requester" never re-picks it;
  // on a voluntary release its req bit is already clear anyway.
  assign others = bus.req & ~gnt_q;
  assign pick   = rr_pick(others, last);

  always_comb begin
    state_n = state;
    owner_n = owner_q;
    last_n  = last;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_n = GRANT;
          owner_n = pick[1:0];
          last_n  = pick[1:0];
          cnt_n   = '0;
          pulse_n = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q] || (cnt == CNT_MAX)) begin
          if (pick[2]) begin
            owner_n = pick[1:0];
            last_n  = pick[1:0];
            cnt_n   = '0;
            pulse_n = 1'b1;
          end else if (!bus.req[owner_q]) begin
            state_n = IDLE;
            owner_n = NO_OWN;
            cnt_n   = '0;
            pulse_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        owner_n = NO_OWN;
      end
    endcase

    // Display follows the post-edge owner; with no owner the last value holds
    case (owner_n)
      2'd0:    disp_n = bus.din0;
      2'd1:    disp_n = bus.din1;
      2'd2:    disp_n = bus.din2;
      default: disp_n = disp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      owner_q <= NO_OWN;
      last    <= 2'd2;
      cnt     <= '0;
      gnt_q   <= 3'b000;
      disp_q  <= '0;
      en_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_n;
      owner_q <= owner_n;
      last    <= last_n;
      cnt     <= cnt_n;
      gnt_q   <= (owner_n == NO_OWN) ? 3'b000 : (3'b001 << owner_n);
      disp_q  <= disp_n;
      en_q    <= (owner_n != NO_OWN);
      pulse_q <= pulse_n;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.owner        = owner_q;
  assign bus.disp_x       = disp_q;
  assign bus.disp_en      = en_q;
  assign bus.switch_pulse = pulse_q;

endmodule
